// File: rtl/video_timing_gen.sv
// Raster timing generator: horizontal/vertical counters, sync/blank decode, line/frame strobes.
// Optional built-in test pattern source is compiled in with `define TEST_PATTERN_EN.
module video_timing_gen #(
    parameter int   H_ACTIVE = 640,
    parameter int   H_FP     = 16,
    parameter int   H_SYNC   = 96,
    parameter int   H_BP     = 48,
    parameter int   V_ACTIVE = 480,
    parameter int   V_FP     = 10,
    parameter int   V_SYNC   = 2,
    parameter int   V_BP     = 33,
    parameter logic HS_POL   = 1'b0,
    parameter logic VS_POL   = 1'b0,
    parameter int   CW       = 12
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          ce,
`ifdef TEST_PATTERN_EN
    input  logic [1:0]    pattern_sel,
    output logic [7:0]    red,
    output logic [7:0]    green,
    output logic [7:0]    blue,
`endif
    output logic          hs,
    output logic          vs,
    output logic          de,
    output logic [CW-1:0] x,
    output logic [CW-1:0] y,
    output logic          line_start,
    output logic          frame_start
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

    localparam logic [CW-1:0] H_LAST     = CW'(H_TOTAL - 1);
    localparam logic [CW-1:0] H_ACT_END  = CW'(H_ACTIVE);
    localparam logic [CW-1:0] H_SYNC_BEG = CW'(H_ACTIVE + H_FP);
    localparam logic [CW-1:0] H_SYNC_END = CW'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [CW-1:0] V_LAST     = CW'(V_TOTAL - 1);
    localparam logic [CW-1:0] V_ACT_END  = CW'(V_ACTIVE);
    localparam logic [CW-1:0] V_SYNC_BEG = CW'(V_ACTIVE + V_FP);
    localparam logic [CW-1:0] V_SYNC_END = CW'(V_ACTIVE + V_FP + V_SYNC);
    localparam logic [CW-1:0] CNT_ONE    = {{(CW-1){1'b0}}, 1'b1};
    localparam logic [CW-1:0] CNT_ZERO   = {CW{1'b0}};

    logic [CW-1:0] hc_r;
    logic [CW-1:0] vc_r;
    logic [CW-1:0] hc_nxt_s;
    logic [CW-1:0] vc_nxt_s;
    logic          hs_nxt_s;
    logic          vs_nxt_s;
    logic          de_nxt_s;
    logic          origin_s;

    // Next counter values: advance only on pixel-enable, vertical steps on horizontal wrap.
    always_comb begin
        hc_nxt_s = hc_r;
        vc_nxt_s = vc_r;
        if (ce) begin
            if (hc_r == H_LAST) begin
                hc_nxt_s = CNT_ZERO;
                if (vc_r == V_LAST) begin
                    vc_nxt_s = CNT_ZERO;
                end else begin
                    vc_nxt_s = vc_r + CNT_ONE;
                end
            end else begin
                hc_nxt_s = hc_r + CNT_ONE;
            end
        end else begin
            hc_nxt_s = hc_r;
            vc_nxt_s = vc_r;
        end
    end

    // Region decode of the current (pre-increment) position.
    always_comb begin
        hs_nxt_s = ~HS_POL;
        vs_nxt_s = ~VS_POL;
        if ((hc_r >= H_SYNC_BEG) && (hc_r < H_SYNC_END)) begin
            hs_nxt_s = HS_POL;
        end else begin
            hs_nxt_s = ~HS_POL;
        end
        if ((vc_r >= V_SYNC_BEG) && (vc_r < V_SYNC_END)) begin
            vs_nxt_s = VS_POL;
        end else begin
            vs_nxt_s = ~VS_POL;
        end
        de_nxt_s = (hc_r < H_ACT_END) && (vc_r < V_ACT_END);
        origin_s = (hc_r == CNT_ZERO) && (vc_r == CNT_ZERO);
    end

    // Counters and timing outputs; strobes are forced low on any non-advancing cycle.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            hc_r        <= CNT_ZERO;
            vc_r        <= CNT_ZERO;
            hs          <= ~HS_POL;
            vs          <= ~VS_POL;
            de          <= 1'b0;
            x           <= CNT_ZERO;
            y           <= CNT_ZERO;
            line_start  <= 1'b0;
            frame_start <= 1'b0;
        end else begin
            hc_r <= hc_nxt_s;
            vc_r <= vc_nxt_s;
            if (ce) begin
                hs          <= hs_nxt_s;
                vs          <= vs_nxt_s;
                de          <= de_nxt_s;
                x           <= hc_r;
                y           <= vc_r;
                line_start  <= (hc_r == CNT_ZERO);
                frame_start <= origin_s;
            end else begin
                line_start  <= 1'b0;
                frame_start <= 1'b0;
            end
        end
    end

`ifdef TEST_PATTERN_EN
    localparam int CWX = CW + 3;

    logic [1:0]   pat_r;
    logic [1:0]   pat_s;
    logic [2:0]   bar_s;
    logic [CWX-1:0] hc_x8_s;
    logic         chk_s;
    logic [7:0]   red_nxt_s;
    logic [7:0]   green_nxt_s;
    logic [7:0]   blue_nxt_s;

    // Pattern source: the selection seen at the frame origin governs the whole frame.
    always_comb begin
        pat_s       = origin_s ? pattern_sel : pat_r;
        hc_x8_s     = {hc_r, 3'b000};
        bar_s       = 3'b000;
        chk_s       = |(((hc_r ^ vc_r) >> 5) & CNT_ONE);
        red_nxt_s   = 8'h00;
        green_nxt_s = 8'h00;
        blue_nxt_s  = 8'h00;
        // Bar index is the largest b with hc*8 >= b*H_ACTIVE, avoiding a divider.
        for (int b = 1; b < 8; b++) begin
            if (hc_x8_s >= CWX'(b * H_ACTIVE)) begin
                bar_s = 3'(b);
            end else begin
                bar_s = bar_s;
            end
        end
        if (de_nxt_s) begin
            case (pat_s)
                2'd0: begin
                    red_nxt_s   = 8'hFF;
                    green_nxt_s = 8'hFF;
                    blue_nxt_s  = 8'hFF;
                end
                2'd1: begin
                    red_nxt_s   = bar_s[1] ? 8'hFF : 8'h00;
                    green_nxt_s = bar_s[2] ? 8'hFF : 8'h00;
                    blue_nxt_s  = bar_s[0] ? 8'hFF : 8'h00;
                end
                2'd2: begin
                    red_nxt_s   = chk_s ? 8'hFF : 8'h00;
                    green_nxt_s = chk_s ? 8'hFF : 8'h00;
                    blue_nxt_s  = chk_s ? 8'hFF : 8'h00;
                end
                2'd3: begin
                    red_nxt_s   = 8'(hc_r);
                    green_nxt_s = 8'(hc_r);
                    blue_nxt_s  = 8'(hc_r);
                end
                default: begin
                    red_nxt_s   = 8'h00;
                    green_nxt_s = 8'h00;
                    blue_nxt_s  = 8'h00;
                end
            endcase
        end else begin
            red_nxt_s   = 8'h00;
            green_nxt_s = 8'h00;
            blue_nxt_s  = 8'h00;
        end
    end

    // Pattern selection latch and colour outputs, aligned with de.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pat_r <= 2'd0;
            red   <= 8'h00;
            green <= 8'h00;
            blue  <= 8'h00;
        end else if (ce) begin
            pat_r <= pat_s;
            red   <= red_nxt_s;
            green <= green_nxt_s;
            blue  <= blue_nxt_s;
        end else begin
            pat_r <= pat_r;
            red   <= red;
            green <= green;
            blue  <= blue;
        end
    end
`endif

endmodule

// File: tb/tb_video_timing_gen.sv
// Randomized bench for video_timing_gen: a position-from-edge-count reference model for a
// reduced raster, plus a tiny-raster instance with active-high syncs.
module tb_video_timing_gen;

    localparam int HA = 40, HF = 3, HSW = 5, HB = 4;
    localparam int VA = 36, VF = 2, VSW = 3, VB = 2;
    localparam int HT = HA + HF + HSW + HB;
    localparam int VT = VA + VF + VSW + VB;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        ce  = 1'b0;
    logic        hs, vs, de, ls, fs;
    logic [11:0] x, y;
    logic [1:0]  psel = 2'd0;
    logic [7:0]  red, green, blue;

    logic        rst_t = 1'b0;
    logic        ce_t  = 1'b1;
    logic        hs_t, vs_t, de_t, ls_t, fs_t;
    logic [11:0] x_t, y_t;
    logic [1:0]  psel_t = 2'd0;
    logic [7:0]  red_t, green_t, blue_t;

    int n_cmp = 0;
    int n_bad = 0;

    // reference model state
    int          n_edges;
    int          m_pat;
    int          e_x, e_y;
    logic        e_hs, e_vs, e_de, e_ls, e_fs;
    logic [23:0] e_rgb;
    int          cyc = 0;
    int          last_fs = -1;
    int          period_mult = 0;

    always #5 clk = ~clk;

    video_timing_gen #(
        .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HSW), .H_BP(HB),
        .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VSW), .V_BP(VB),
        .HS_POL(1'b0), .VS_POL(1'b0), .CW(12)
    ) dut (
        .clk(clk), .rst(rst), .ce(ce),
`ifdef TEST_PATTERN_EN
        .pattern_sel(psel), .red(red), .green(green), .blue(blue),
`endif
        .hs(hs), .vs(vs), .de(de), .x(x), .y(y),
        .line_start(ls), .frame_start(fs)
    );

    video_timing_gen #(
        .H_ACTIVE(4), .H_FP(1), .H_SYNC(1), .H_BP(1),
        .V_ACTIVE(2), .V_FP(1), .V_SYNC(1), .V_BP(1),
        .HS_POL(1'b1), .VS_POL(1'b1), .CW(12)
    ) dut_tiny (
        .clk(clk), .rst(rst_t), .ce(ce_t),
`ifdef TEST_PATTERN_EN
        .pattern_sel(psel_t), .red(red_t), .green(green_t), .blue(blue_t),
`endif
        .hs(hs_t), .vs(vs_t), .de(de_t), .x(x_t), .y(y_t),
        .line_start(ls_t), .frame_start(fs_t)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: observed %0h expected %0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    function automatic logic [23:0] model_rgb(input int pat, input int px, input int py);
        int   bar;
        logic [7:0] r, g, b;
        r = 8'h00; g = 8'h00; b = 8'h00;
        case (pat)
            0: begin r = 8'hFF; g = 8'hFF; b = 8'hFF; end
            1: begin
                bar = (px * 8) / HA;
                r = ((bar & 2) != 0) ? 8'hFF : 8'h00;
                g = ((bar & 4) != 0) ? 8'hFF : 8'h00;
                b = ((bar & 1) != 0) ? 8'hFF : 8'h00;
            end
            2: if ((((px / 32) ^ (py / 32)) & 1) != 0) begin
                r = 8'hFF; g = 8'hFF; b = 8'hFF;
            end
            3: begin r = 8'(px % 256); g = r; b = r; end
            default: ;
        endcase
        return {r, g, b};
    endfunction

    task automatic model_reset();
        n_edges = 0; m_pat = 0;
        e_x = 0; e_y = 0; e_de = 1'b0; e_hs = 1'b1; e_vs = 1'b1;
        e_ls = 1'b0; e_fs = 1'b0; e_rgb = 24'h000000;
    endtask

    // one DUT clock edge as the specification describes it, from the count of ce edges
    task automatic model_edge();
        if (ce) begin
            e_x  = n_edges % HT;
            e_y  = (n_edges / HT) % VT;
            e_ls = (e_x == 0);
            e_fs = (e_x == 0) && (e_y == 0);
            if (e_fs) m_pat = int'(psel);
            e_de = (e_x < HA) && (e_y < VA);
            e_hs = !((e_x >= HA + HF) && (e_x < HA + HF + HSW));
            e_vs = !((e_y >= VA + VF) && (e_y < VA + VF + VSW));
            e_rgb = e_de ? model_rgb(m_pat, e_x, e_y) : 24'h000000;
            n_edges++;
        end else begin
            e_ls = 1'b0;
            e_fs = 1'b0;
        end
    endtask

    task automatic compare_all();
        check("x", 32'(x), 32'(e_x));
        check("y", 32'(y), 32'(e_y));
        check("de", 32'(de), 32'(e_de));
        check("hs", 32'(hs), 32'(e_hs));
        check("vs", 32'(vs), 32'(e_vs));
        check("line_start", 32'(ls), 32'(e_ls));
        check("frame_start", 32'(fs), 32'(e_fs));
`ifdef TEST_PATTERN_EN
        check("rgb", {8'h00, red, green, blue}, {8'h00, e_rgb});
`endif
    endtask

    // called at a negedge: drive ce, take one edge, compare at the next negedge
    task automatic cycle(input logic ce_v);
        ce = ce_v;
        @(posedge clk);
        model_edge();
        @(negedge clk);
        cyc++;
        compare_all();
        if (period_mult != 0 && fs === 1'b1) begin
            if (last_fs >= 0) check("fs_period", 32'(cyc - last_fs), 32'(period_mult * HT * VT));
            last_fs = cyc;
        end
    endtask

    task automatic do_reset(input int clks);
        rst = 1'b0;
        #1;
        model_reset();
        compare_all();
        repeat (clks) begin
            @(posedge clk);
            @(negedge clk);
            compare_all();
        end
        rst = 1'b1;
    endtask

    initial begin
        int de_cnt, hs_cnt, vs_cnt;
        @(negedge clk);
        do_reset(2);

        // continuous ce, gray ramp selected before the first frame
        psel = 2'd3;
        period_mult = 1; last_fs = -1; de_cnt = 0;
        for (int i = 0; i < HT * VT + 20; i++) begin
            cycle(1'b1);
            if (i < HT * VT && de === 1'b1) de_cnt++;
        end
        check("de_per_frame", 32'(de_cnt), 32'(HA * VA));

        // ce alternating: periods double, strobes stay one clock wide
        psel = 2'd1;
        period_mult = 2; last_fs = -1;
        for (int i = 0; i < 2 * 2 * HT * VT + 40; i++) cycle(i % 2 == 0);
        period_mult = 0;

        // random ce and random mid-frame pattern changes
        for (int i = 0; i < 6000; i++) begin
            if ($urandom_range(0, 199) == 0) psel = 2'($urandom_range(0, 3));
            cycle($urandom_range(0, 3) != 0);
        end

        // reset in the middle of a frame, then restart from the origin
        for (int i = 0; i < 700 + $urandom_range(0, 300); i++) cycle($urandom_range(0, 1) == 1);
        psel = 2'd2;
        do_reset(3);
        for (int i = 0; i < HT * VT + 10; i++) cycle($urandom_range(0, 4) != 0);

        // tiny raster: H_TOTAL 7, V_TOTAL 5, active-high syncs
        ce = 1'b0;
        #1;
        check("tiny_rst_hs", 32'(hs_t), 32'(0));
        check("tiny_rst_vs", 32'(vs_t), 32'(0));
        @(negedge clk);
        rst_t = 1'b1;
        de_cnt = 0; hs_cnt = 0; vs_cnt = 0;
        for (int k = 0; k < 35; k++) begin
            @(posedge clk);
            @(negedge clk);
            check("tiny_x", 32'(x_t), 32'(k % 7));
            check("tiny_y", 32'(y_t), 32'((k / 7) % 5));
            check("tiny_hs", 32'(hs_t), 32'((k % 7) == 5));
            check("tiny_vs", 32'(vs_t), 32'(((k / 7) % 5) == 3));
            check("tiny_fs", 32'(fs_t), 32'(k == 0));
            if (de_t === 1'b1) de_cnt++;
            if (hs_t === 1'b1) hs_cnt++;
            if (vs_t === 1'b1) vs_cnt++;
        end
        check("tiny_de_count", 32'(de_cnt), 32'(8));
        check("tiny_hs_count", 32'(hs_cnt), 32'(5));
        check("tiny_vs_count", 32'(vs_cnt), 32'(7));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
